// File: rtl/mips_pkg.sv
// Shared MIPS definitions: primary opcodes (identical to the main decoder's),
// the loader's instruction-kind encoding and the loader state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Kinds 6 and 7 are illegal.
  typedef enum logic [2:0] {
    KIND_LW    = 3'd0,
    KIND_SW    = 3'd1,
    KIND_RTYPE = 3'd2,
    KIND_ADDI  = 3'd3,
    KIND_BEQ   = 3'd4,
    KIND_J     = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: instruction kind plus raw fields -> 32-bit MIPS word.
// Ports:
//   kind                       instruction kind (see mips_pkg::kind_e)
//   rs, rt, rd, shamt, funct   register / R-type fields
//   imm, target                I-type immediate, J-type target
//   word                       encoded instruction (0 when illegal)
//   illegal                    kind is not one of the six supported kinds
module instr_field_encoder
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_LW:    word = {OP_LW,    rs, rt, imm};
      KIND_SW:    word = {OP_SW,    rs, rt, imm};
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_ADDI:  word = {OP_ADDI,  rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ,   rs, rt, imm};
      KIND_J:     word = {OP_J,     target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: encodes instruction descriptions from a
// valid/ready stream and writes them to consecutive instruction-memory
// words, holding the core in reset until the program is complete.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  pulse: begin a session at address 0
//   in_valid/in_ready      description handshake
//   in_kind .. in_target   description fields; in_last marks the final one
//   imem_we/addr/wdata     registered instruction-memory write port
//   cpu_hold               1 = core held in reset
//   done, err              program loaded / sticky error
//   count                  words written this session
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | after reset, waiting for start
// LOAD    | accepting descriptions, one write per accepted beat
// DONE    | program complete, core released (one cycle later)
// ERROR   | illegal kind or memory overflow, core held
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  load_state_e       state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;

  instr_field_encoder u_enc (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept = in_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    count_d      = count_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal) begin
            state_d = ST_ERROR;
          end else begin
            // The next free address is the low part of count; count itself
            // may reach 2^ADDR_W on an exact fill.
            imem_we_d    = 1'b1;
            imem_addr_d  = count_q[ADDR_W-1:0];
            imem_wdata_d = DATA_W'(enc_word);
            count_d      = count_q + (ADDR_W+1)'(1);
            if (in_last)
              state_d = ST_DONE;
            else if (count_q[ADDR_W-1:0] == ADDR_MAX)
              state_d = ST_ERROR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d     = ST_LOAD;
          imem_addr_d = '0;
          count_d     = '0;
        end
      end
    endcase
    // Status flags follow the state one cycle later; start clears them at once.
    done_d     = (state_q == ST_DONE)  && !start;
    err_d      = (state_q == ST_ERROR) && !start;
    cpu_hold_d = !done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      count_q      <= count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = cpu_hold_q;

endmodule
